gated_integrator_ctrl: RTL and testbench

- Trigger-driven sequencer for one gated_integrator instance.
- On each trigger it clears the integrator and gates exactly n input samples into it. It drives the integrator's external address bus, waits a fixed pipeline latency, then captures the window sum.
- The captured sum is presented on a valid/ready result port.
- Sits between the ADC sample stream / trigger logic and the event readout.

---
 rtl/gated_integrator_ctrl.sv | 155 +++++++++++++++
 tb/tb_gated_integrator_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gated_integrator_ctrl.sv
// gated_integrator_ctrl: trigger-driven sequencer for one gated_integrator.
// Each accepted trigger clears the integrator, gates n samples into it, waits
// for the integrator pipeline to settle and presents the window sum on a
// valid/ready result port.
// Optional idle-sample watchdog: define GI_CTRL_TIMEOUT_EN.
module gated_integrator_ctrl #(
   parameter int P_NBITS_ADDR     = 6,
   parameter int P_NBITS_DATA_OUT = 20,
   parameter int P_GI_LATENCY     = 3,
   parameter int P_NBITS_DROP     = 16,
   parameter int P_TIMEOUT        = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        trig,
   input  logic [P_NBITS_ADDR-1:0]     cfg_n,
   input  logic                        din_v,
   output logic                        gi_rst,
   output logic [P_NBITS_ADDR-1:0]     gi_n,
   output logic                        gi_wr,
   output logic                        gi_addr_en,
   output logic [P_NBITS_ADDR-1:0]     gi_addr,
   input  logic [P_NBITS_DATA_OUT-1:0] gi_sum,
   output logic [P_NBITS_DATA_OUT-1:0] res,
   output logic [P_NBITS_ADDR-1:0]     res_n,
   output logic                        res_err,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        busy,
   output logic [P_NBITS_DROP-1:0]     drop_cnt
);

   localparam logic [P_NBITS_ADDR-1:0] N_MIN    = P_NBITS_ADDR'(2);
   localparam logic [3:0]              LAT_LAST = 4'(P_GI_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FILL, S_SETTLE, S_HOLD
   } state_t;

   state_t                  state, state_nxt;
   logic [P_NBITS_ADDR-1:0] wcnt;
   logic [P_NBITS_ADDR-1:0] n_last;
   logic [3:0]              lcnt;
   logic                    wr_en, wr_last, settle_done;
   logic                    timeout, timed_out;

   assign gi_addr_en  = 1'b1;
   assign n_last      = gi_n - P_NBITS_ADDR'(1);
   assign wr_en       = (state == S_FILL) && din_v;
   assign wr_last     = wr_en && (wcnt == n_last);
   assign settle_done = (state == S_SETTLE) && (lcnt == LAT_LAST);

`ifdef GI_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(P_TIMEOUT + 1);
   logic [WD_W-1:0] wd;

   assign timeout = (state == S_FILL) && !din_v && (wd == WD_W'(P_TIMEOUT - 1));

   // watchdog over consecutive idle FILL cycles; the abort flag lives until the next CLEAR
   always_ff @(posedge clk) begin
      if (rst) begin
         wd        <= '0;
         timed_out <= 1'b0;
      end else begin
         if (state != S_FILL || din_v) wd <= '0;
         else                          wd <= wd + WD_W'(1);
         if (state == S_CLEAR)         timed_out <= 1'b0;
         else if (timeout)             timed_out <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (P_TIMEOUT > 0);
   assign timeout        = 1'b0;
   assign timed_out      = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state and per-state outputs; gi_wr is din_v gated by FILL
   always_comb begin
      state_nxt = state;
      gi_wr     = 1'b0;
      busy      = 1'b1;
      res_valid = 1'b0;
      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (trig) state_nxt = S_CLEAR;
         end
         S_CLEAR: state_nxt = S_FILL;
         S_FILL: begin
            gi_wr = din_v;
            if (wr_last || timeout) state_nxt = S_SETTLE;
         end
         S_SETTLE: if (settle_done) state_nxt = S_SETTLE == S_SETTLE ? S_HOLD : S_HOLD;
         S_HOLD: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // window datapath: length latch, address/write/latency counters, result capture, drop count
   always_ff @(posedge clk) begin
      if (rst) begin
         gi_rst   <= 1'b1;
         gi_addr  <= '0;
         gi_n     <= N_MIN;
         wcnt     <= '0;
         lcnt     <= '0;
         res      <= '0;
         res_n    <= '0;
         res_err  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         // integrator clear is high exactly while in CLEAR
         gi_rst <= (state_nxt == S_CLEAR);
         if (state == S_IDLE && trig)
            gi_n <= (cfg_n < N_MIN) ? N_MIN : cfg_n;
         if (trig && state != S_IDLE && drop_cnt != '1)
            drop_cnt <= drop_cnt + P_NBITS_DROP'(1);
         case (state)
            S_CLEAR: begin
               gi_addr <= '0;
               wcnt    <= '0;
            end
            S_FILL: begin
               lcnt <= '0;
               if (wr_en) begin
                  gi_addr <= (gi_addr == n_last) ? '0 : gi_addr + P_NBITS_ADDR'(1);
                  wcnt    <= wcnt + P_NBITS_ADDR'(1);
               end
            end
            S_SETTLE: begin
               lcnt <= lcnt + 4'd1;
               if (settle_done) begin
                  res     <= gi_sum;
                  // an aborted window reports the writes actually made
                  res_n   <= timed_out ? wcnt : gi_n;
                  res_err <= timed_out;
               end
            end
            S_HOLD: if (res_ready) res_err <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gated_integrator_ctrl.sv
// Bench for gated_integrator_ctrl: behavioural integrator model plus a
// scoreboard of expected window results, one task per scenario.
module tb_gated_integrator_ctrl;

   localparam int A   = 6;
   localparam int D   = 20;
   localparam int DR  = 4;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          rst, trig, din_v, res_ready;
   logic [A-1:0]  cfg_n;
   logic          gi_rst, gi_wr, gi_addr_en, res_err, res_valid, busy;
   logic [A-1:0]  gi_n, gi_addr, res_n;
   logic [D-1:0]  gi_sum, res, acc;
   logic [DR-1:0] drop_cnt;
   logic [7:0]    d;

   int checks = 0, failures = 0;
   int cyc = 0, wr_cnt = 0, bad_wr = 0, last_wr_cyc = 0, valid_cyc = 0;
   logic [A-1:0] wr_log [0:255];

   typedef struct {
      logic [D-1:0] res;
      logic [A-1:0] n;
      logic         err;
   } exp_t;
   exp_t exp_q[$];

   gated_integrator_ctrl #(
      .P_NBITS_ADDR(A), .P_NBITS_DATA_OUT(D), .P_GI_LATENCY(LAT),
      .P_NBITS_DROP(DR), .P_TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .trig(trig), .cfg_n(cfg_n), .din_v(din_v),
      .gi_rst(gi_rst), .gi_n(gi_n), .gi_wr(gi_wr), .gi_addr_en(gi_addr_en),
      .gi_addr(gi_addr), .gi_sum(gi_sum), .res(res), .res_n(res_n),
      .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // integrator model: clear on gi_rst, accumulate d on gi_wr
   always @(posedge clk) begin
      if (gi_rst === 1'b1)     acc <= '0;
      else if (gi_wr === 1'b1) acc <= acc + D'(d);
   end
   assign gi_sum = acc;

   // write monitor: logs address of every gated write
   always @(negedge clk) begin
      if (gi_wr === 1'b1) begin
         wr_log[wr_cnt[7:0]] = gi_addr;
         wr_cnt = wr_cnt + 1;
         last_wr_cyc = cyc;
         if (din_v !== 1'b1) bad_wr = bad_wr + 1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // trigger a window and feed nsamp samples; expected result goes to the scoreboard
   task automatic drive_window(input int cfg, input bit toggle, input int nsamp, input int base);
      int   n_l, sum, sent, k;
      exp_t e;
      n_l = (cfg < 2) ? 2 : cfg;
      sum = 0; sent = 0; k = 0;
      cfg_n = A'(cfg); trig = 1'b1; tick; trig = 1'b0; tick;
      while (sent < nsamp) begin
         if (toggle && (k % 2 == 1)) din_v = 1'b0;
         else begin
            din_v = 1'b1;
            d = 8'(base + sent);
            if (sent < n_l) sum += base + sent;
            sent++;
         end
         k++;
         tick;
      end
      din_v = 1'b0;
      e.res = D'(sum); e.n = A'(n_l); e.err = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (res_valid === 1'b1) begin ok = 1'b1; valid_cyc = cyc; break; end
         tick;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; din_v = 1'b1; tick; tick;
      checks++; if (gi_rst !== 1'b1) begin failures++; $display("FAIL rst_gi_rst: got %0b exp 1", gi_rst); end
      checks++; if (gi_wr !== 1'b0) begin failures++; $display("FAIL rst_gi_wr: got %0b exp 0", gi_wr); end
      checks++; if (gi_addr !== '0 || gi_n !== A'(2) || gi_addr_en !== 1'b1) begin
         failures++; $display("FAIL rst_gi_bus: got addr=%0d n=%0d en=%0b exp 0 2 1", gi_addr, gi_n, gi_addr_en); end
      checks++; if ({res, res_n, res_err, res_valid, busy, drop_cnt} !== '0) begin
         failures++; $display("FAIL rst_outputs: got res=%0d n=%0d err=%0b v=%0b busy=%0b drop=%0d exp all 0",
                              res, res_n, res_err, res_valid, busy, drop_cnt); end
      rst = 1'b0; tick; tick;
      checks++; if (gi_rst !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL rst_release: got gi_rst=%0b busy=%0b exp 0 0", gi_rst, busy); end
      checks++; if (wr_cnt != 0) begin failures++; $display("FAIL idle_no_write: got %0d exp 0", wr_cnt); end
      din_v = 1'b0;
   endtask

   task automatic test_basic;
      int w0; bit ok, seq; exp_t e;
      w0 = wr_cnt;
      drive_window(4, 1'b0, 6, 1);
      checks++; if (gi_n !== A'(4)) begin failures++; $display("FAIL basic_gi_n: got %0d exp 4", gi_n); end
      wait_valid(20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_valid: got no res_valid exp res_valid"); end
      e = exp_q.pop_front();
      checks++; if (res !== e.res || res_n !== e.n || res_err !== e.err) begin
         failures++; $display("FAIL basic_res: got %0d/%0d/%0b exp %0d/%0d/%0b", res, res_n, res_err, e.res, e.n, e.err); end
      checks++; if (wr_cnt - w0 != 4) begin failures++; $display("FAIL basic_wr_cnt: got %0d exp 4", wr_cnt - w0); end
      seq = 1'b1;
      for (int i = 0; i < 4; i++) if (wr_log[w0 + i] !== A'(i)) seq = 1'b0;
      checks++; if (!seq) begin failures++; $display("FAIL basic_addr_seq: got %0d,%0d,%0d,%0d exp 0,1,2,3",
                                                    wr_log[w0], wr_log[w0+1], wr_log[w0+2], wr_log[w0+3]); end
      checks++; if (valid_cyc - last_wr_cyc != LAT + 1) begin
         failures++; $display("FAIL basic_latency: got %0d exp %0d", valid_cyc - last_wr_cyc, LAT + 1); end
      res_ready = 1'b1; tick; res_ready = 1'b0;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL basic_handshake: got v=%0b busy=%0b exp 0 0", res_valid, busy); end
   endtask

   task automatic test_clamp;
      int w0; bit ok; exp_t e;
      for (int c = 1; c >= 0; c--) begin
         w0 = wr_cnt;
         drive_window(c, 1'b0, 4, 10);
         checks++; if (gi_n !== A'(2)) begin failures++; $display("FAIL clamp_gi_n cfg=%0d: got %0d exp 2", c, gi_n); end
         wait_valid(20, ok);
         e = exp_q.pop_front();
         checks++; if (!ok || res !== e.res || res_n !== e.n) begin
            failures++; $display("FAIL clamp_res cfg=%0d: got %0d/%0d exp %0d/%0d", c, res, res_n, e.res, e.n); end
         checks++; if (wr_cnt - w0 != 2) begin failures++; $display("FAIL clamp_wr_cnt cfg=%0d: got %0d exp 2", c, wr_cnt - w0); end
         res_ready = 1'b1; tick; res_ready = 1'b0;
      end
   endtask

   task automatic test_drops;
      bit ok, stable; exp_t e;
      cfg_n = A'(8); trig = 1'b1; tick; trig = 1'b0; tick;
      for (int k = 0; k < 8; k++) begin
         din_v = 1'b1; d = 8'(k + 1);
         trig = (k == 1 || k == 3 || k == 5);
         tick;
      end
      trig = 1'b0; din_v = 1'b0;
      e.res = D'(36); e.n = A'(8); e.err = 1'b0; exp_q.push_back(e);
      wait_valid(20, ok);
      e = exp_q.pop_front();
      trig = 1'b1; tick; trig = 1'b0;
      stable = ok;
      for (int i = 0; i < 10; i++) begin
         if (res !== e.res || res_n !== e.n || res_valid !== 1'b1) stable = 1'b0;
         tick;
      end
      checks++; if (!stable) begin failures++; $display("FAIL drop_hold_stable: got %0d/%0d v=%0b exp %0d/%0d v=1", res, res_n, res_valid, e.res, e.n); end
      checks++; if (drop_cnt !== DR'(4)) begin failures++; $display("FAIL drop_cnt4: got %0d exp 4", drop_cnt); end
      // trig coinciding with the handshake is dropped, not accepted
      res_ready = 1'b1; trig = 1'b1; tick; res_ready = 1'b0; trig = 1'b0;
      checks++; if (drop_cnt !== DR'(5)) begin failures++; $display("FAIL drop_cnt_simul: got %0d exp 5", drop_cnt); end
      tick;
      checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
         failures++; $display("FAIL drop_idle: got busy=%0b v=%0b exp 0 0", busy, res_valid); end
      drive_window(2, 1'b0, 2, 1);
      wait_valid(20, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || res !== e.res) begin failures++; $display("FAIL drop_win2_res: got %0d exp %0d", res, e.res); end
      trig = 1'b1;
      repeat (12) tick;
      trig = 1'b0;
      checks++; if (drop_cnt !== DR'(15)) begin failures++; $display("FAIL drop_saturate: got %0d exp 15", drop_cnt); end
      res_ready = 1'b1; tick; res_ready = 1'b0;
   endtask

   task automatic test_wrap;
      int w0, b0; bit ok, seq; exp_t e;
      w0 = wr_cnt; b0 = bad_wr;
      drive_window(8, 1'b1, 8, 40);
      wait_valid(30, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || res !== e.res || res_n !== e.n) begin
         failures++; $display("FAIL wrap_res: got %0d/%0d exp %0d/%0d", res, res_n, e.res, e.n); end
      seq = (wr_cnt - w0 == 8);
      for (int i = 0; i < 8; i++) if (wr_log[w0 + i] !== A'(i)) seq = 1'b0;
      checks++; if (!seq) begin failures++; $display("FAIL wrap_addr_seq: got %0d writes last=%0d exp 8 writes 0..7", wr_cnt - w0, wr_log[w0+7]); end
      checks++; if (bad_wr != b0) begin failures++; $display("FAIL wrap_write_on_idle: got %0d exp 0", bad_wr - b0); end
      checks++; if (gi_addr !== '0) begin failures++; $display("FAIL wrap_addr_final: got %0d exp 0", gi_addr); end
      res_ready = 1'b1; tick; res_ready = 1'b0;
   endtask

   task automatic test_rst_mid;
      int w0; bit ok; exp_t e;
      cfg_n = A'(8); trig = 1'b1; tick; trig = 1'b0; tick;
      for (int k = 0; k < 3; k++) begin din_v = 1'b1; d = 8'(k + 1); tick; end
      din_v = 1'b0; rst = 1'b1; tick; rst = 1'b0;
      checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || gi_rst !== 1'b1 || drop_cnt !== '0) begin
         failures++; $display("FAIL rstmid_state: got busy=%0b v=%0b gi_rst=%0b drop=%0d exp 0 0 1 0", busy, res_valid, gi_rst, drop_cnt); end
      tick;
      w0 = wr_cnt;
      drive_window(8, 1'b0, 10, 20);
      wait_valid(20, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || res !== e.res || res_n !== e.n) begin
         failures++; $display("FAIL rstmid_res: got %0d/%0d exp %0d/%0d", res, res_n, e.res, e.n); end
      checks++; if (wr_cnt - w0 != 8) begin failures++; $display("FAIL rstmid_wr_cnt: got %0d exp 8", wr_cnt - w0); end
      res_ready = 1'b1; tick; res_ready = 1'b0;
   endtask

`ifdef GI_CTRL_TIMEOUT_EN
   task automatic test_timeout;
      bit ok; exp_t e;
      cfg_n = A'(8); trig = 1'b1; tick; trig = 1'b0; tick;
      din_v = 1'b1; d = 8'd5; tick;
      d = 8'd7; tick;
      din_v = 1'b0;
      e.res = D'(12); e.n = A'(2); e.err = 1'b1; exp_q.push_back(e);
      wait_valid(40, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || res !== e.res || res_n !== e.n || res_err !== e.err) begin
         failures++; $display("FAIL timeout_res: got %0d/%0d/%0b exp %0d/%0d/%0b", res, res_n, res_err, e.res, e.n, e.err); end
      res_ready = 1'b1; tick; res_ready = 1'b0;
      checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: got %0b exp 0", res_err); end
   endtask
`endif

   initial begin
      rst = 1'b1; trig = 1'b0; cfg_n = '0; din_v = 1'b0; d = '0; res_ready = 1'b0;
      test_reset;
      test_basic;
      test_clamp;
      test_drops;
      test_wrap;
      test_rst_mid;
`ifdef GI_CTRL_TIMEOUT_EN
      test_timeout;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
